// File: rtl/sprite_pkg.sv
// Shared constants, state encoding and width helpers for the sprite bank
// and its per-channel serialisers.
package sprite_pkg;

    localparam logic [1:0] SPR_OFF_POS  = 2'd0;
    localparam logic [1:0] SPR_OFF_CTL  = 2'd1;
    localparam logic [1:0] SPR_OFF_DATA = 2'd2;
    localparam logic [1:0] SPR_OFF_DATB = 2'd3;

    localparam logic [8:0] SPR_BASE_LO = 9'h140;
    localparam logic [8:0] SPR_BASE_HI = 9'h1C0;

    typedef enum logic [1:0] {
        SPR_DISARMED = 2'd0,
        SPR_ARMED    = 2'd1,
        SPR_SHIFTING = 2'd2
    } spr_state_e;

    function automatic int spr_clog2(input int value);
        int w;
        w = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) w = i + 1;
        end
        return w;
    endfunction

    // Colour index: pair number above a 2-bit pixel, never narrower than 4 bits.
    function automatic int spr_sd_width(input int num_spr);
        int w;
        w = spr_clog2(num_spr / 2) + 2;
        return (w < 4) ? 4 : w;
    endfunction

endpackage

// File: rtl/sprite_channel.sv
// One sprite channel: POS/CTL/DATA/DATB registers, arm/shift state machine,
// a pair of DATW-bit shifters and the remaining-pixel counter.
module sprite_channel
    import sprite_pkg::*;
#(
    parameter int DATW = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            wr_pos_i,
    input  logic            wr_ctl_i,
    input  logic            wr_data_i,
    input  logic            wr_datb_i,
    input  logic [DATW-1:0] datain_i,
    input  logic [8:0]      horbeam_i,
    input  logic            pix_en_i,
    output logic [1:0]      pix_o,
    output logic            attach_o
);

    localparam int CNT_W = spr_clog2(DATW);

    spr_state_e       state_q;
    logic [8:0]       hstart_q;
    logic             attach_q;
    logic [DATW-1:0]  datla_q;
    logic [DATW-1:0]  datlb_q;
    logic [DATW-1:0]  shifta_q;
    logic [DATW-1:0]  shiftb_q;
    logic [CNT_W-1:0] cnt_q;
    logic             start_match;

    assign start_match = pix_en_i && (horbeam_i == hstart_q);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= SPR_DISARMED;
            hstart_q <= '0;
            attach_q <= 1'b0;
            datla_q  <= '0;
            datlb_q  <= '0;
            shifta_q <= '0;
            shiftb_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (wr_pos_i) hstart_q[8:1] <= datain_i[7:0];
            if (wr_ctl_i) begin
                hstart_q[0] <= datain_i[0];
                attach_q    <= datain_i[7];
            end
            if (wr_data_i) datla_q <= datain_i;
            if (wr_datb_i) datlb_q <= datain_i;

            if (wr_ctl_i) begin
                state_q  <= SPR_DISARMED;
                shifta_q <= '0;
                shiftb_q <= '0;
                cnt_q    <= '0;
            end else begin
                unique case (state_q)
                    SPR_DISARMED: begin
                        if (wr_data_i) state_q <= SPR_ARMED;
                    end
                    default: begin
                        // A fresh match always wins, even mid-shift: restart the line.
                        if (start_match) begin
                            state_q  <= SPR_SHIFTING;
                            shifta_q <= datla_q;
                            shiftb_q <= datlb_q;
                            cnt_q    <= CNT_W'(DATW - 1);
                        end else if (state_q == SPR_SHIFTING && pix_en_i) begin
                            shifta_q <= {shifta_q[DATW-2:0], 1'b0};
                            shiftb_q <= {shiftb_q[DATW-2:0], 1'b0};
                            if (cnt_q == '0) state_q <= SPR_ARMED;
                            else             cnt_q   <= cnt_q - 1'b1;
                        end
                    end
                endcase
            end
        end
    end

    assign pix_o    = (state_q == SPR_SHIFTING) ? {shifta_q[DATW-1], shiftb_q[DATW-1]} : 2'b00;
    assign attach_o = attach_q;

endmodule

// File: rtl/sprite_bank.sv
// Bank of NUM_SPR sprite channels with register decode and the pairwise
// priority/attach mixer feeding the playfield priority logic.
module sprite_bank
    import sprite_pkg::*;
#(
    parameter  int NUM_SPR         = 8,
    parameter  int DATW            = 16,
    parameter  int ATTACH_ODD_ONLY = 1,
    localparam int SD_W            = spr_sd_width(NUM_SPR)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [8:1]         regaddress,
    input  logic [DATW-1:0]    datain,
    input  logic [8:0]         horbeam,
    input  logic               pix_en,
    output logic [NUM_SPR-1:0] nsprite,
    output logic [SD_W-1:0]    sprdata,
    output logic               spr_att
);

    localparam int NUM_PAIRS = NUM_SPR / 2;

    logic [1:0]           pix [NUM_SPR];
    logic [NUM_SPR-1:0]   attach;
    logic [NUM_PAIRS-1:0] pair_att;
    logic                 found;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_SPR; gi++) begin : g_chan
            localparam logic [8:0] CH_BASE = (gi < 8) ? SPR_BASE_LO : SPR_BASE_HI;
            logic sel;

            assign sel = (regaddress[8:6] == CH_BASE[8:6]) && (regaddress[5:3] == 3'(gi % 8));

            sprite_channel #(
                .DATW(DATW)
            ) u_chan (
                .clk      (clk),
                .reset    (reset),
                .wr_pos_i (sel && (regaddress[2:1] == SPR_OFF_POS)),
                .wr_ctl_i (sel && (regaddress[2:1] == SPR_OFF_CTL)),
                .wr_data_i(sel && (regaddress[2:1] == SPR_OFF_DATA)),
                .wr_datb_i(sel && (regaddress[2:1] == SPR_OFF_DATB)),
                .datain_i (datain),
                .horbeam_i(horbeam),
                .pix_en_i (pix_en),
                .pix_o    (pix[gi]),
                .attach_o (attach[gi])
            );

            assign nsprite[gi] = (pix[gi] != 2'b00);
        end

        for (gi = 0; gi < NUM_PAIRS; gi++) begin : g_pair
            assign pair_att[gi] = (ATTACH_ODD_ONLY != 0) ? attach[2*gi+1]
                                                         : (attach[2*gi] | attach[2*gi+1]);
        end
    endgenerate

    // Lowest-numbered pair with any visible pixel owns the output.
    always_comb begin
        sprdata = '0;
        spr_att = 1'b0;
        found   = 1'b0;
        for (int p = 0; p < NUM_PAIRS; p++) begin
            if (!found && (nsprite[2*p] || nsprite[2*p+1])) begin
                found = 1'b1;
                if (pair_att[p]) begin
                    sprdata = SD_W'({pix[2*p+1], pix[2*p]});
                    spr_att = 1'b1;
                end else if (nsprite[2*p]) begin
                    sprdata = (SD_W'(p) << 2) | SD_W'(pix[2*p]);
                end else begin
                    sprdata = (SD_W'(p) << 2) | SD_W'(pix[2*p+1]);
                end
            end
        end
    end

endmodule

// File: tb/tb_sprite_bank.sv
// Two sprite banks (16-bit odd-attach and 64-bit either-attach) driven in
// parallel and compared cycle by cycle against a behavioural model.
module tb_sprite_bank;

    localparam logic [8:1] IDLE = 8'h00;

    logic        clk        = 1'b0;
    logic        reset      = 1'b0;
    logic [8:1]  regaddress = IDLE;
    logic [63:0] datain     = '0;
    logic [8:0]  horbeam    = '0;
    logic        pix_en     = 1'b0;

    logic [7:0] ns_a, ns_b;
    logic [3:0] sd_a, sd_b;
    logic       at_a, at_b;

    int errors = 0;
    int checks = 0;

    sprite_bank #(.NUM_SPR(8), .DATW(16), .ATTACH_ODD_ONLY(1)) dut_a (
        .clk(clk), .reset(reset), .regaddress(regaddress), .datain(datain[15:0]),
        .horbeam(horbeam), .pix_en(pix_en), .nsprite(ns_a), .sprdata(sd_a), .spr_att(at_a)
    );

    sprite_bank #(.NUM_SPR(8), .DATW(64), .ATTACH_ODD_ONLY(0)) dut_b (
        .clk(clk), .reset(reset), .regaddress(regaddress), .datain(datain),
        .horbeam(horbeam), .pix_en(pix_en), .nsprite(ns_b), .sprdata(sd_b), .spr_att(at_b)
    );

    always #5 clk = ~clk;

    // Model: per channel a mode (0 idle, 1 armed, 2 showing), a snapshot of the
    // line data and the index of the pixel currently on screen.
    int          W        [2] = '{16, 64};
    bit          odd_only [2] = '{1'b1, 1'b0};
    logic [8:0]  m_hs  [2][8];
    bit          m_att [2][8];
    logic [63:0] m_la  [2][8];
    logic [63:0] m_lb  [2][8];
    logic [63:0] m_sa  [2][8];
    logic [63:0] m_sb  [2][8];
    int          m_st  [2][8];
    int          m_pos [2][8];

    logic [7:0] e_ns [2];
    logic [3:0] e_sd [2];
    logic       e_at [2];

    function automatic logic [63:0] rnd64();
        return {$urandom(), $urandom()};
    endfunction

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            for (int k = 0; k < 8; k++) begin
                m_hs[m][k] = '0; m_att[m][k] = 1'b0; m_la[m][k] = '0; m_lb[m][k] = '0;
                m_sa[m][k] = '0; m_sb[m][k] = '0; m_st[m][k] = 0; m_pos[m][k] = 0;
            end
        end
    endtask

    task automatic model_step();
        int addr, ch, off;
        bit hit;
        logic [63:0] mask;
        addr = int'({regaddress, 1'b0});
        ch = -1;
        off = 0;
        if (addr >= 'h140 && addr < 'h180) begin
            ch  = (addr - 'h140) / 8;
            off = (addr / 2) % 4;
        end
        for (int m = 0; m < 2; m++) begin
            mask = (W[m] == 64) ? '1 : ((64'd1 << W[m]) - 64'd1);
            for (int k = 0; k < 8; k++) begin
                hit = pix_en && (horbeam == m_hs[m][k]) && (m_st[m][k] != 0);
                if (ch == k && off == 1) begin
                    m_st[m][k] = 0;
                    m_pos[m][k] = 0;
                end else if (m_st[m][k] == 0) begin
                    if (ch == k && off == 2) m_st[m][k] = 1;
                end else if (hit) begin
                    m_st[m][k] = 2; m_sa[m][k] = m_la[m][k]; m_sb[m][k] = m_lb[m][k]; m_pos[m][k] = 0;
                end else if (m_st[m][k] == 2 && pix_en) begin
                    if (m_pos[m][k] == W[m] - 1) m_st[m][k] = 1;
                    else                         m_pos[m][k]++;
                end
                if (ch == k) begin
                    case (off)
                        0: m_hs[m][k][8:1] = datain[7:0];
                        1: begin m_hs[m][k][0] = datain[0]; m_att[m][k] = datain[7]; end
                        2: m_la[m][k] = datain & mask;
                        default: m_lb[m][k] = datain & mask;
                    endcase
                end
            end
        end
    endtask

    function automatic logic [1:0] m_pix(input int m, input int k);
        int b;
        if (m_st[m][k] != 2) return 2'b00;
        b = W[m] - 1 - m_pos[m][k];
        return {m_sa[m][k][b], m_sb[m][k][b]};
    endfunction

    task automatic model_out(input int m, output logic [7:0] ns, output logic [3:0] sd, output logic at);
        logic [1:0] px [8];
        bit done, joined;
        ns = '0; sd = '0; at = 1'b0; done = 1'b0;
        for (int k = 0; k < 8; k++) begin
            px[k] = m_pix(m, k);
            ns[k] = (px[k] != 2'b00);
        end
        for (int p = 0; p < 4; p++) begin
            if (!done && (ns[2*p] || ns[2*p+1])) begin
                done = 1'b1;
                joined = odd_only[m] ? m_att[m][2*p+1] : (m_att[m][2*p] || m_att[m][2*p+1]);
                if (joined) begin
                    sd = {px[2*p+1], px[2*p]};
                    at = 1'b1;
                end else begin
                    sd = 4'(p * 4 + int'(ns[2*p] ? px[2*p] : px[2*p+1]));
                end
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        model_out(0, e_ns[0], e_sd[0], e_at[0]);
        model_out(1, e_ns[1], e_sd[1], e_at[1]);
    endtask

    task automatic wr(input logic [8:0] a, input logic [63:0] d);
        regaddress = a[8:1];
        datain = d;
        tick();
        regaddress = IDLE;
    endtask

    task automatic do_reset();
        reset = 1'b0; regaddress = IDLE; datain = '0; horbeam = '0; pix_en = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        model_out(0, e_ns[0], e_sd[0], e_at[0]);
        model_out(1, e_ns[1], e_sd[1], e_at[1]);
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if ({ns_a, sd_a, at_a, ns_b, sd_b, at_b} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got a=%h/%h/%b b=%h/%h/%b want all zero", ns_a, sd_a, at_a, ns_b, sd_b, at_b);
        end
        do_reset();
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if ({ns_a, sd_a, at_a, ns_b, sd_b, at_b} !== {e_ns[0], e_sd[0], e_at[0], e_ns[1], e_sd[1], e_at[1]}) begin
                errors++;
                $display("FAIL reset_idle got a=%h/%h/%b b=%h/%h/%b want a=%h/%h/%b b=%h/%h/%b",
                         ns_a, sd_a, at_a, ns_b, sd_b, at_b, e_ns[0], e_sd[0], e_at[0], e_ns[1], e_sd[1], e_at[1]);
            end
        end
        $display("test_reset done");
    endtask

    task automatic test_basic_16();
        int cnt, first;
        do_reset();
        wr(9'h140, 64'h40); wr(9'h142, 64'h0); wr(9'h144, 64'hFFFF); wr(9'h146, 64'h0);
        cnt = 0; first = -1;
        for (int h = 0; h < 512; h++) begin
            horbeam = 9'(h); pix_en = 1'b1;
            tick();
            checks++;
            if ({ns_a, sd_a, at_a, ns_b, sd_b, at_b} !== {e_ns[0], e_sd[0], e_at[0], e_ns[1], e_sd[1], e_at[1]}) begin
                errors++;
                $display("FAIL basic16_model h=%0h got a=%h/%h/%b b=%h/%h/%b want a=%h/%h/%b b=%h/%h/%b", h,
                         ns_a, sd_a, at_a, ns_b, sd_b, at_b, e_ns[0], e_sd[0], e_at[0], e_ns[1], e_sd[1], e_at[1]);
            end
            if (ns_a[0]) begin
                if (first < 0) first = h;
                cnt++;
                checks++;
                if (sd_a !== 4'b0010) begin
                    errors++;
                    $display("FAIL basic16_sprdata h=%0h got %b want 0010", h, sd_a);
                end
            end
        end
        checks++;
        if (first != 'h80) begin errors++; $display("FAIL basic16_start got %0h want 80", first); end
        checks++;
        if (cnt != 16) begin errors++; $display("FAIL basic16_len got %0d want 16", cnt); end
        $display("test_basic_16 done: %0d pixels from h=%0h", cnt, first);
    endtask

    task automatic test_wide_64();
        int cnt_a, cnt_b;
        do_reset();
        wr(9'h148, 64'h20); wr(9'h14A, 64'h0); wr(9'h14E, 64'h0); wr(9'h14C, '1);
        for (int line = 0; line < 2; line++) begin
            cnt_a = 0; cnt_b = 0;
            for (int h = 0; h < 512; h++) begin
                horbeam = 9'(h); pix_en = 1'b1;
                tick();
                checks++;
                if ({ns_a, sd_a, at_a, ns_b, sd_b, at_b} !== {e_ns[0], e_sd[0], e_at[0], e_ns[1], e_sd[1], e_at[1]}) begin
                    errors++;
                    $display("FAIL wide64_model line=%0d h=%0h got a=%h/%h/%b b=%h/%h/%b want a=%h/%h/%b b=%h/%h/%b", line, h,
                             ns_a, sd_a, at_a, ns_b, sd_b, at_b, e_ns[0], e_sd[0], e_at[0], e_ns[1], e_sd[1], e_at[1]);
                end
                if (ns_a[1]) cnt_a++;
                if (ns_b[1]) cnt_b++;
            end
            checks++;
            if (cnt_b != 64) begin errors++; $display("FAIL wide64_len line=%0d got %0d want 64", line, cnt_b); end
            checks++;
            if (cnt_a != 16) begin errors++; $display("FAIL wide64_len16 line=%0d got %0d want 16", line, cnt_a); end
            $display("test_wide_64 line %0d: %0d wide pixels, %0d narrow pixels", line, cnt_b, cnt_a);
        end
    endtask

    task automatic test_pix_en();
        int cnt;
        do_reset();
        wr(9'h140, 64'h40); wr(9'h142, 64'h0); wr(9'h146, 64'h0); wr(9'h144, 64'hFFFF);
        horbeam = 9'h80; pix_en = 1'b0;
        tick();
        checks++;
        if (ns_a[0] !== 1'b0 || ns_b[0] !== 1'b0) begin
            errors++;
            $display("FAIL pixen_noload got a=%b b=%b want 0 0", ns_a[0], ns_b[0]);
        end
        cnt = 0;
        for (int h = 'h80; h <= 'h100; h++) begin
            for (int ph = 0; ph < 2; ph++) begin
                horbeam = 9'(h); pix_en = (ph == 0);
                tick();
                checks++;
                if ({ns_a, sd_a, at_a, ns_b, sd_b, at_b} !== {e_ns[0], e_sd[0], e_at[0], e_ns[1], e_sd[1], e_at[1]}) begin
                    errors++;
                    $display("FAIL pixen_model h=%0h ph=%0d got a=%h/%h/%b b=%h/%h/%b want a=%h/%h/%b b=%h/%h/%b", h, ph,
                             ns_a, sd_a, at_a, ns_b, sd_b, at_b, e_ns[0], e_sd[0], e_at[0], e_ns[1], e_sd[1], e_at[1]);
                end
                if (ns_a[0]) cnt++;
            end
        end
        checks++;
        if (cnt != 32) begin errors++; $display("FAIL pixen_len got %0d want 32", cnt); end
        $display("test_pix_en done: %0d cycles visible", cnt);
    endtask

    task automatic attach_sweep(input int phase);
        for (int h = 0; h <= 'h70; h++) begin
            horbeam = 9'(h); pix_en = 1'b1;
            tick();
            checks++;
            if ({ns_a, sd_a, at_a, ns_b, sd_b, at_b} !== {e_ns[0], e_sd[0], e_at[0], e_ns[1], e_sd[1], e_at[1]}) begin
                errors++;
                $display("FAIL attach_model phase=%0d h=%0h got a=%h/%h/%b b=%h/%h/%b want a=%h/%h/%b b=%h/%h/%b", phase, h,
                         ns_a, sd_a, at_a, ns_b, sd_b, at_b, e_ns[0], e_sd[0], e_at[0], e_ns[1], e_sd[1], e_at[1]);
            end
            if (h == 'h64) begin
                checks++;
                if (phase == 0 && {at_a, sd_a, at_b, sd_b} !== {1'b1, 4'b1011, 1'b1, 4'b1011}) begin
                    errors++;
                    $display("FAIL attach_odd got a=%b/%b b=%b/%b want 1/1011 1/1011", at_a, sd_a, at_b, sd_b);
                end
                if (phase == 1 && {at_a, sd_a, at_b, sd_b} !== {1'b0, 4'b0111, 1'b1, 4'b1011}) begin
                    errors++;
                    $display("FAIL attach_even got a=%b/%b b=%b/%b want 0/0111 1/1011", at_a, sd_a, at_b, sd_b);
                end
            end
        end
    endtask

    task automatic test_attach();
        do_reset();
        wr(9'h150, 64'h30); wr(9'h152, 64'h00); wr(9'h158, 64'h30); wr(9'h15A, 64'h80);
        wr(9'h154, '1); wr(9'h156, '1); wr(9'h15C, '1); wr(9'h15E, 64'h0);
        attach_sweep(0);
        wr(9'h152, 64'h80); wr(9'h15A, 64'h00); wr(9'h154, '1); wr(9'h15C, '1);
        attach_sweep(1);
        $display("test_attach done");
    endtask

    task automatic test_overlap();
        do_reset();
        wr(9'h140, 64'h30); wr(9'h142, 64'h0); wr(9'h146, 64'h0); wr(9'h144, '1);
        wr(9'h160, 64'h30); wr(9'h162, 64'h0); wr(9'h166, 64'h0); wr(9'h164, '1);
        for (int h = 0; h <= 'h70; h++) begin
            horbeam = 9'(h); pix_en = 1'b1;
            tick();
            checks++;
            if ({ns_a, sd_a, at_a, ns_b, sd_b, at_b} !== {e_ns[0], e_sd[0], e_at[0], e_ns[1], e_sd[1], e_at[1]}) begin
                errors++;
                $display("FAIL overlap_model h=%0h got a=%h/%h/%b b=%h/%h/%b want a=%h/%h/%b b=%h/%h/%b", h,
                         ns_a, sd_a, at_a, ns_b, sd_b, at_b, e_ns[0], e_sd[0], e_at[0], e_ns[1], e_sd[1], e_at[1]);
            end
            if (h == 'h64) begin
                checks++;
                if ({ns_a, sd_a, at_a, ns_b, sd_b} !== {8'h11, 4'b0010, 1'b0, 8'h11, 4'b0010}) begin
                    errors++;
                    $display("FAIL overlap_pair0 got a=%h/%b/%b b=%h/%b want 11/0010/0 11/0010", ns_a, sd_a, at_a, ns_b, sd_b);
                end
            end
        end
        $display("test_overlap done");
    endtask

    task automatic test_ctl_and_reset();
        int hits;
        do_reset();
        wr(9'h140, 64'h40); wr(9'h142, 64'h0); wr(9'h146, 64'h0); wr(9'h144, '1);
        hits = 0;
        for (int line = 0; line < 2; line++) begin
            for (int h = 0; h < 512; h++) begin
                horbeam = 9'(h); pix_en = 1'b1;
                if (line == 0 && h == 'h84) begin regaddress = 9'h142 >> 1; datain = '0; end
                else regaddress = IDLE;
                tick();
                checks++;
                if ({ns_a, sd_a, at_a, ns_b, sd_b, at_b} !== {e_ns[0], e_sd[0], e_at[0], e_ns[1], e_sd[1], e_at[1]}) begin
                    errors++;
                    $display("FAIL ctl_model line=%0d h=%0h got a=%h/%h/%b b=%h/%h/%b want a=%h/%h/%b b=%h/%h/%b", line, h,
                             ns_a, sd_a, at_a, ns_b, sd_b, at_b, e_ns[0], e_sd[0], e_at[0], e_ns[1], e_sd[1], e_at[1]);
                end
                if ((line == 1 || h >= 'h84) && (ns_a[0] || ns_b[0])) hits++;
            end
        end
        regaddress = IDLE;
        checks++;
        if (hits != 0) begin errors++; $display("FAIL ctl_disarm got %0d visible cycles want 0", hits); end
        wr(9'h144, '1);
        for (int h = 0; h <= 'h85; h++) begin
            horbeam = 9'(h); pix_en = 1'b1;
            tick();
        end
        checks++;
        if (ns_a[0] !== 1'b1 || ns_b[0] !== 1'b1) begin
            errors++;
            $display("FAIL ctl_rearm got a=%b b=%b want 1 1", ns_a[0], ns_b[0]);
        end
        #2 reset = 1'b0;
        #1;
        checks++;
        if ({ns_a, sd_a, at_a, ns_b, sd_b, at_b} !== '0) begin
            errors++;
            $display("FAIL async_reset got a=%h/%h/%b b=%h/%h/%b want all zero", ns_a, sd_a, at_a, ns_b, sd_b, at_b);
        end
        do_reset();
        $display("test_ctl_and_reset done");
    endtask

    task automatic test_random();
        int bad;
        do_reset();
        for (int k = 0; k < 8; k++) begin
            wr(9'(9'h140 + k * 8), 64'($urandom_range(0, 255)));
            wr(9'(9'h142 + k * 8), 64'($urandom_range(0, 255)));
            wr(9'(9'h146 + k * 8), rnd64());
            wr(9'(9'h144 + k * 8), rnd64());
        end
        bad = 0;
        for (int i = 0; i < 2500; i++) begin
            pix_en = ($urandom_range(0, 3) != 0);
            if (pix_en) horbeam = horbeam + 9'd1;
            if ($urandom_range(0, 31) == 0) begin
                regaddress = 8'(($urandom_range(0, 7) * 8 + $urandom_range(0, 3) * 2 + 'h140) >> 1);
                datain = rnd64();
            end else begin
                regaddress = IDLE;
            end
            tick();
            checks++;
            if ({ns_a, sd_a, at_a, ns_b, sd_b, at_b} !== {e_ns[0], e_sd[0], e_at[0], e_ns[1], e_sd[1], e_at[1]}) begin
                errors++;
                bad++;
                if (bad < 10)
                    $display("FAIL random_model i=%0d h=%0h got a=%h/%h/%b b=%h/%h/%b want a=%h/%h/%b b=%h/%h/%b", i, horbeam,
                             ns_a, sd_a, at_a, ns_b, sd_b, at_b, e_ns[0], e_sd[0], e_at[0], e_ns[1], e_sd[1], e_at[1]);
            end
        end
        regaddress = IDLE;
        $display("test_random done: %0d mismatching cycles", bad);
    endtask

    initial begin
        test_reset();
        test_basic_16();
        test_wide_64();
        test_pix_en();
        test_attach();
        test_overlap();
        test_ctl_and_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
